// File: rtl/operand_fetch_pkg.sv
// ----------------------------------------------------------------------------
// operand_fetch_pkg
//   Shared widths, instruction field positions and FSM state encodings for the
//   operand-fetch stage. The project-wide macros (`WIDTH, `REG_ADDR_LEN,
//   `NUM_REGS, field positions, state codes) are defined here once, behind an
//   include guard. They are mirrored as package localparams so that importing
//   files only depend on the package.
//   Ports: none (package).
// ----------------------------------------------------------------------------
`ifndef OPERAND_FETCH_PARAMS_DEFINED
`define OPERAND_FETCH_PARAMS_DEFINED
`define WIDTH          32
`define REG_ADDR_LEN   5
`define NUM_REGS       32
`define OPCODE_HI      31
`define OPCODE_LO      26
`define RC_HI          25
`define RC_LO          21
`define RA_HI          20
`define RA_LO          16
`define RB_HI          15
`define RB_LO          11
`define IMM_HI         15
`define IMM_LO         0
`define ST_IDLE        2'd0
`define ST_CHECK       2'd1
`define ST_READ        2'd2
`define ST_VALID       2'd3
`endif

package operand_fetch_pkg;

    localparam int WIDTH        = `WIDTH;
    localparam int REG_ADDR_LEN = `REG_ADDR_LEN;
    localparam int NUM_REGS     = `NUM_REGS;
    localparam int OPCODE_W     = `OPCODE_HI - `OPCODE_LO + 1;
    localparam int IMM_W        = `IMM_HI - `IMM_LO + 1;

    localparam logic [1:0] ST_IDLE  = `ST_IDLE;
    localparam logic [1:0] ST_CHECK = `ST_CHECK;
    localparam logic [1:0] ST_READ  = `ST_READ;
    localparam logic [1:0] ST_VALID = `ST_VALID;

    function automatic logic [OPCODE_W-1:0] f_opcode(input logic [WIDTH-1:0] instr);
        return instr[`OPCODE_HI:`OPCODE_LO];
    endfunction

    function automatic logic [REG_ADDR_LEN-1:0] f_rc(input logic [WIDTH-1:0] instr);
        return instr[`RC_HI:`RC_LO];
    endfunction

    function automatic logic [REG_ADDR_LEN-1:0] f_ra(input logic [WIDTH-1:0] instr);
        return instr[`RA_HI:`RA_LO];
    endfunction

    function automatic logic [REG_ADDR_LEN-1:0] f_rb(input logic [WIDTH-1:0] instr);
        return instr[`RB_HI:`RB_LO];
    endfunction

    function automatic logic [IMM_W-1:0] f_imm(input logic [WIDTH-1:0] instr);
        return instr[`IMM_HI:`IMM_LO];
    endfunction

endpackage

// File: rtl/operand_fetch_scoreboard.sv
// ----------------------------------------------------------------------------
// scoreboard
//   One busy bit per architectural register. A bit is set when an instruction
//   that writes that register leaves operand fetch, and cleared when the
//   register file is written back. Register 0 is never busy.
//   Ports:
//     i_clk, i_rst_n        clock, asynchronous active-low reset
//     i_set_en, i_set_idx   mark a register busy at the next rising edge
//     i_clr_en, i_clr_idx   mark a register free at the next rising edge
//     i_query_a/b           registers to look up
//     o_busy_a/b            busy state of the queried registers
//     o_busy                full busy vector (observation)
// ----------------------------------------------------------------------------
module scoreboard
    import operand_fetch_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_set_en,
    input  logic [REG_ADDR_LEN-1:0] i_set_idx,
    input  logic                    i_clr_en,
    input  logic [REG_ADDR_LEN-1:0] i_clr_idx,
    input  logic [REG_ADDR_LEN-1:0] i_query_a,
    input  logic [REG_ADDR_LEN-1:0] i_query_b,
    output logic                    o_busy_a,
    output logic                    o_busy_b,
    output logic [NUM_REGS-1:0]     o_busy
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;

    // Clear is applied first so a set of the same bit in the same cycle wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en) begin
            w_busy_nxt[i_clr_idx] = 1'b0;
        end
        if (i_set_en) begin
            w_busy_nxt[i_set_idx] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign o_busy_a = r_busy[i_query_a];
    assign o_busy_b = r_busy[i_query_b];
    assign o_busy   = r_busy;

endmodule

// File: rtl/operand_fetch.sv
// ----------------------------------------------------------------------------
// operand_fetch
//   Accepts one instruction, waits until its source registers are not busy,
//   reads them from an external register file and presents an operand bundle
//   to execute. The register file samples rf_ra/rf_rb on the falling edge of
//   the READ cycle, so its data is captured at the rising edge leaving READ.
//   Ports:
//     clk, rst_n                 clock, asynchronous active-low reset
//     in_valid/in_ready/in_instr upstream instruction handshake
//     rf_ra, rf_rb, rf_r_en      register-file read request
//     rf_dataA, rf_dataB         register-file read data
//     wb_en, wb_rc               writeback notification (clears busy bit)
//     out_valid/out_ready        downstream bundle handshake
//     out_opcode, out_rc, out_a, out_b, out_imm   operand bundle
//     o_dbg_state                current FSM state
//     o_dbg_busy                 scoreboard busy vector
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both 1. While out_valid is 1 the bundle is held stable until out_ready.
//   in_ready may depend combinationally on out_ready so a new instruction can
//   be accepted in the same cycle the previous bundle is taken.
// ----------------------------------------------------------------------------
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_instr,
    output logic [REG_ADDR_LEN-1:0] rf_ra,
    output logic [REG_ADDR_LEN-1:0] rf_rb,
    output logic                    rf_r_en,
    input  logic [WIDTH-1:0]        rf_dataA,
    input  logic [WIDTH-1:0]        rf_dataB,
    input  logic                    wb_en,
    input  logic [REG_ADDR_LEN-1:0] wb_rc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OPCODE_W-1:0]     out_opcode,
    output logic [REG_ADDR_LEN-1:0] out_rc,
    output logic [WIDTH-1:0]        out_a,
    output logic [WIDTH-1:0]        out_b,
    output logic [IMM_W-1:0]        out_imm,
    output logic [1:0]              o_dbg_state,
    output logic [NUM_REGS-1:0]     o_dbg_busy
);

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [WIDTH-1:0]        r_instr;
    logic [OPCODE_W-1:0]     r_out_opcode;
    logic [REG_ADDR_LEN-1:0] r_out_rc;
    logic [WIDTH-1:0]        r_out_a;
    logic [WIDTH-1:0]        r_out_b;
    logic [IMM_W-1:0]        r_out_imm;

    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_out_fire;
    logic                    w_busy_a;
    logic                    w_busy_b;
    logic                    w_set_en;
    logic [REG_ADDR_LEN-1:0] w_ra;
    logic [REG_ADDR_LEN-1:0] w_rb;
    logic                    w_addr_phase;

    assign w_ra       = f_ra(r_instr);
    assign w_rb       = f_rb(r_instr);
    assign w_out_fire = (r_state == ST_VALID) && out_ready;
    assign w_in_ready = (r_state == ST_IDLE) || w_out_fire;
    assign w_accept   = in_valid && w_in_ready;
    // Destination becomes busy once the bundle is handed to execute.
    assign w_set_en   = w_out_fire && (r_out_rc != '0);

    scoreboard u_scoreboard (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_set_en  (w_set_en),
        .i_set_idx (r_out_rc),
        .i_clr_en  (wb_en),
        .i_clr_idx (wb_rc),
        .i_query_a (w_ra),
        .i_query_b (w_rb),
        .o_busy_a  (w_busy_a),
        .o_busy_b  (w_busy_b),
        .o_busy    (o_dbg_busy)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // Register 0 is never busy, so ra/rb = 0 cannot stall here.
                if (!(w_busy_a || w_busy_b)) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                w_state_nxt = ST_VALID;
            end
            ST_VALID: begin
                if (out_ready) begin
                    w_state_nxt = w_accept ? ST_CHECK : ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_instr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_instr <= in_instr;
            end
        end
    end

    // The bundle is captured at the edge that leaves READ, after the register
    // file has driven data for the addresses presented during READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_opcode <= '0;
            r_out_rc     <= '0;
            r_out_a      <= '0;
            r_out_b      <= '0;
            r_out_imm    <= '0;
        end else if (r_state == ST_READ) begin
            r_out_opcode <= f_opcode(r_instr);
            r_out_rc     <= f_rc(r_instr);
            r_out_a      <= rf_dataA;
            r_out_b      <= rf_dataB;
            r_out_imm    <= f_imm(r_instr);
        end
    end

    assign w_addr_phase = (r_state == ST_CHECK) || (r_state == ST_READ);

    assign rf_ra       = w_addr_phase ? w_ra : '0;
    assign rf_rb       = w_addr_phase ? w_rb : '0;
    assign rf_r_en     = (r_state == ST_READ);
    assign in_ready    = w_in_ready;
    assign out_valid   = (r_state == ST_VALID);
    assign out_opcode  = r_out_opcode;
    assign out_rc      = r_out_rc;
    assign out_a       = r_out_a;
    assign out_b       = r_out_b;
    assign out_imm     = r_out_imm;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_operand_fetch.sv
// ----------------------------------------------------------------------------
// tb_operand_fetch
//   Directed bench for operand_fetch with a behavioural register file
//   (falling-edge read, rising-edge write), an expected-bundle queue filled by
//   the stimulus thread and a monitor that pops on each output handshake.
// ----------------------------------------------------------------------------
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    localparam int BW = OPCODE_W + REG_ADDR_LEN + 2 * WIDTH + IMM_W;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_instr;
    logic [REG_ADDR_LEN-1:0] rf_ra;
    logic [REG_ADDR_LEN-1:0] rf_rb;
    logic                    rf_r_en;
    logic [WIDTH-1:0]        rf_dataA;
    logic [WIDTH-1:0]        rf_dataB;
    logic                    wb_en;
    logic [REG_ADDR_LEN-1:0] wb_rc;
    logic [WIDTH-1:0]        wb_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [OPCODE_W-1:0]     out_opcode;
    logic [REG_ADDR_LEN-1:0] out_rc;
    logic [WIDTH-1:0]        out_a;
    logic [WIDTH-1:0]        out_b;
    logic [IMM_W-1:0]        out_imm;
    logic [1:0]              dbg_state;
    logic [NUM_REGS-1:0]     dbg_busy;

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic [BW-1:0]    exp_q [$];
    logic [BW-1:0]    mon_exp;
    logic [BW-1:0]    hold_exp;
    int               n_checks = 0;
    int               n_pass   = 0;
    int               cyc;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    operand_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .rf_ra       (rf_ra),
        .rf_rb       (rf_rb),
        .rf_r_en     (rf_r_en),
        .rf_dataA    (rf_dataA),
        .rf_dataB    (rf_dataB),
        .wb_en       (wb_en),
        .wb_rc       (wb_rc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_opcode  (out_opcode),
        .out_rc      (out_rc),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_imm     (out_imm),
        .o_dbg_state (dbg_state),
        .o_dbg_busy  (dbg_busy)
    );

    // ---------------- register file model ----------------
    always @(negedge clk) begin
        if (rf_r_en) begin
            rf_dataA = regs[rf_ra];
            rf_dataB = regs[rf_rb];
        end
    end

    always @(posedge clk) begin
        if (wb_en && (wb_rc != '0)) begin
            regs[wb_rc] = wb_data;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [IMM_W-1:0] mk_imm(input logic [4:0] rb, input logic [10:0] low);
        return {rb, low};
    endfunction

    function automatic logic [WIDTH-1:0] mk_instr(input logic [5:0] op, input logic [4:0] rc,
                                                  input logic [4:0] ra, input logic [15:0] imm);
        return {op, rc, ra, imm};
    endfunction

    function automatic logic [BW-1:0] mk_exp(input logic [5:0] op, input logic [4:0] rc,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [15:0] imm);
        return {op, rc, a, b, imm};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic [WIDTH-1:0] instr);
        in_valid = 1'b1;
        in_instr = instr;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    // Called one step after the accept edge; counts cycles until out_valid.
    task automatic wait_out(output int n);
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) begin
            chk("valid_timeout", 0, 1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bundle", {5'd0, out_opcode, out_rc, out_a, out_b, out_imm}, 96'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("bundle", {5'd0, out_opcode, out_rc, out_a, out_b, out_imm}, {5'd0, mon_exp});
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        out_ready = 1'b1;
        wb_en     = 1'b0;
        wb_rc     = '0;
        wb_data   = '0;
        rf_dataA  = '0;
        rf_dataB  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] = '0;
        end
        regs[3] = 32'h11;
        regs[4] = 32'h22;
        regs[5] = 32'h55;

        // Reset state
        #12;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_rf_r_en", rf_r_en, 0);
        chk("reset_outputs", {out_opcode, out_rc, out_a, out_b, out_imm}, 0);
        chk("reset_rf_addr", {rf_ra, rf_rb}, 0);
        chk("reset_busy", dbg_busy, 0);
        chk("reset_state", dbg_state, ST_IDLE);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        chk("in_ready_after_reset", in_ready, 1);

        // ra=3, rb=4: CHECK, READ, VALID on the 3rd cycle after acceptance
        exp_q.push_back(mk_exp(6'd1, 5'd0, 32'h11, 32'h22, mk_imm(5'd4, 11'h123)));
        send(mk_instr(6'd1, 5'd0, 5'd3, mk_imm(5'd4, 11'h123)));
        chk("basic_state_check", dbg_state, ST_CHECK);
        chk("basic_rf_r_en_check", rf_r_en, 0);
        step();
        chk("basic_state_read", dbg_state, ST_READ);
        chk("basic_rf_r_en_read", rf_r_en, 1);
        chk("basic_rf_addr", {rf_ra, rf_rb}, {5'd3, 5'd4});
        step();
        chk("basic_out_valid", out_valid, 1);
        step();
        chk("basic_back_to_idle", dbg_state, ST_IDLE);

        // ra=0, rb=0: zeros, no stall
        exp_q.push_back(mk_exp(6'd2, 5'd0, 32'h0, 32'h0, mk_imm(5'd0, 11'h7ff)));
        send(mk_instr(6'd2, 5'd0, 5'd0, mk_imm(5'd0, 11'h7ff)));
        wait_out(cyc);
        chk("zero_regs_latency", cyc, 3);
        step();

        // Producer rc=5 then consumer ra=5 stalls until writeback
        exp_q.push_back(mk_exp(6'd3, 5'd5, 32'h0, 32'h0, mk_imm(5'd0, 11'h055)));
        send(mk_instr(6'd3, 5'd5, 5'd0, mk_imm(5'd0, 11'h055)));
        wait_out(cyc);
        step();
        chk("busy5_set", dbg_busy[5], 1);
        exp_q.push_back(mk_exp(6'd6, 5'd0, 32'h99, 32'h0, mk_imm(5'd0, 11'h001)));
        send(mk_instr(6'd6, 5'd0, 5'd5, mk_imm(5'd0, 11'h001)));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_state", dbg_state, ST_CHECK);
            chk("stall_rf_r_en", rf_r_en, 0);
        end
        wb_en   = 1'b1;
        wb_rc   = 5'd5;
        wb_data = 32'h99;
        step();
        wb_en = 1'b0;
        chk("busy5_cleared", dbg_busy[5], 0);
        wait_out(cyc);
        chk("post_wb_latency", cyc, 3);
        step();

        // Backpressure: bundle held stable, then back-to-back acceptance
        out_ready = 1'b0;
        hold_exp  = mk_exp(6'd4, 5'd6, 32'h11, 32'h22, mk_imm(5'd4, 11'h0aa));
        exp_q.push_back(hold_exp);
        exp_q.push_back(mk_exp(6'd5, 5'd0, 32'h11, 32'h0, mk_imm(5'd0, 11'h3cc)));
        send(mk_instr(6'd4, 5'd6, 5'd3, mk_imm(5'd4, 11'h0aa)));
        wait_out(cyc);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_bundle", {5'd0, out_opcode, out_rc, out_a, out_b, out_imm}, {5'd0, hold_exp});
            chk("hold_in_ready", in_ready, 0);
            chk("hold_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_instr  = mk_instr(6'd5, 5'd0, 5'd3, mk_imm(5'd0, 11'h3cc));
        @(negedge clk);
        chk("b2b_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        chk("b2b_state", dbg_state, ST_CHECK);
        chk("busy6_set", dbg_busy[6], 1);
        wait_out(cyc);
        chk("b2b_latency", cyc, 3);
        step();

        // Set and clear of the same bit in one cycle: set wins
        exp_q.push_back(mk_exp(6'd7, 5'd7, 32'h0, 32'h0, mk_imm(5'd0, 11'h007)));
        send(mk_instr(6'd7, 5'd7, 5'd0, mk_imm(5'd0, 11'h007)));
        wait_out(cyc);
        wb_en   = 1'b1;
        wb_rc   = 5'd7;
        wb_data = 32'h77;
        step();
        wb_en = 1'b0;
        chk("busy7_set_wins", dbg_busy[7], 1);
        wb_en = 1'b1;
        step();
        wb_en = 1'b0;
        chk("busy7_cleared", dbg_busy[7], 0);

        // Reset during READ discards the instruction
        send(mk_instr(6'd8, 5'd8, 5'd3, mk_imm(5'd4, 11'h0f0)));
        step();
        chk("pre_reset_state", dbg_state, ST_READ);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_reset_state", dbg_state, ST_IDLE);
        chk("mid_reset_out_valid", out_valid, 0);
        chk("mid_reset_rf_r_en", rf_r_en, 0);
        chk("mid_reset_rf_addr", {rf_ra, rf_rb}, 0);
        chk("mid_reset_outputs", {out_opcode, out_rc, out_a, out_b, out_imm}, 0);
        chk("mid_reset_busy", dbg_busy, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        exp_q.push_back(mk_exp(6'd9, 5'd0, 32'h11, 32'h22, mk_imm(5'd4, 11'h111)));
        send(mk_instr(6'd9, 5'd0, 5'd3, mk_imm(5'd4, 11'h111)));
        wait_out(cyc);
        chk("post_reset_latency", cyc, 3);
        step();

        // Final report
        repeat (3) step();
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameters: none; widths come from the `WIDTH (32), `REG_ADDR_LEN (5) and `NUM_REGS (32) macros in params.v.
REQ-002 clk  input  1  single clock, rising-edge logic; the register file samples its read ports on the falling edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 in_valid  input  1  upstream instruction valid.
REQ-005 in_ready  output  1  block can accept an instruction.
REQ-006 in_instr  input  `WIDTH  instruction; fields: opcode[31:26], rc[25:21], ra[20:16], rb[15:11], imm[15:0].
REQ-007 rf_ra, rf_rb  output  `REG_ADDR_LEN each  register-file read addresses.
REQ-008 rf_r_en  output  1  register-file read enable.
REQ-009 rf_dataA, rf_dataB  input  `WIDTH each  register-file read data.
REQ-010 wb_en  input  1  writeback to register file this cycle.
REQ-011 wb_rc  input  `REG_ADDR_LEN  writeback destination.
REQ-012 out_valid  output  1  operand bundle valid toward execute.
REQ-013 out_ready  input  1  execute accepts the bundle.
REQ-014 out_opcode  output  6; out_rc  output  `REG_ADDR_LEN; out_a, out_b  output  `WIDTH; out_imm  output  16.

Function
REQ-015 FSM states: IDLE, CHECK, READ, VALID; encoding free.
REQ-016 in_ready is 1 only in IDLE, and in VALID during the cycle out_ready=1.
REQ-017 Acceptance (in_valid && in_ready): latch in_instr into an instruction register; next state CHECK.
REQ-018 Scoreboard: `NUM_REGS busy bits; bit 0 is hard-wired 0.
REQ-019 CHECK: if busy[ra] or busy[rb], stay in CHECK (stall); otherwise go to READ.
REQ-020 rf_ra/rf_rb are driven from the instruction register in CHECK and READ; rf_r_en=1 only in READ.
REQ-021 Leaving READ at the rising edge: capture rf_dataA/rf_dataB into out_a/out_b, copy opcode/rc/imm into outputs, go to VALID. Read latency is exactly 1 cycle in READ.
REQ-022 VALID: out_valid=1, and out_* stay stable until out_ready=1.
REQ-023 On out_valid && out_ready: set busy[out_rc] if out_rc!=0; next state is CHECK if a new instruction is accepted in the same cycle, otherwise IDLE.
REQ-024 wb_en=1 clears busy[wb_rc] at the rising edge.
REQ-025 Set and clear of the same bit in the same cycle: set wins.
REQ-026 A hazard clears in the cycle after the wb_en edge; READ then occurs no earlier than one cycle after the register-file write, so no bypass path is needed.
REQ-027 ra=0 or rb=0 never stalls.
REQ-028 Throughput: at most one instruction per 3 cycles without stalls (CHECK, READ, VALID).

Reset
REQ-029 rst_n=0 forces IDLE asynchronously.
REQ-030 On reset, all busy bits clear, out_valid=0, in_ready=1 (after reset), rf_r_en=0, and out_*, rf_ra and rf_rb are 0.
REQ-031 Reset asserted mid-operation discards the in-flight instruction; no busy bit survives.

Structure
REQ-032 Instruction field positions and state encodings are `define macros in params.v, next to `WIDTH and `NUM_REGS.
REQ-033 The scoreboard (set/clear/query, 32 bits) is a separate sub-module: scoreboard.
REQ-034 The register file is instantiated outside this block, not inside it.

Verification
REQ-035 Reset, then instr ra=3, rb=4 with the register file preloaded R3=0x11, R4=0x22 -> out_valid on the 3rd cycle after acceptance; out_a=0x11, out_b=0x22.
REQ-036 ra=0, rb=0 -> out_a=0, out_b=0, no stall.
REQ-037 Issue rc=5, then ra=5 and hold wb_en off for 4 cycles -> FSM stays in CHECK with rf_r_en=0. Pulse wb_en (wb_rc=5, data 0x99) -> out_a=0x99.
REQ-038 out_ready held 0 for 5 cycles in VALID -> out_* stable and in_ready=0. Then out_ready=1 with in_valid=1 -> back-to-back acceptance into CHECK.
REQ-039 wb_en with wb_rc=7 in the same cycle as issue of rc=7 -> busy[7]=1.
REQ-040 Assert rst_n=0 while in READ -> outputs zero immediately and busy all 0. After release, the next instruction completes normally.
